friscv_cache_wr_arbiter: RTL
============================

# friscv_cache_wr_arbiter

Arbiter and scheduler for the single data-cache block write port. It is shared between the fetcher's line-fill path and the pusher's write-through update path. The fetcher has priority; a streak limit prevents the pusher from starving. When a fill and an update target the same block in the same cycle, they are merged into one write. The block sits between those two producers and the cache block RAM, and it drives that RAM's write port directly.

## Interface
Parameters:
- AXI_ADDR_W, 8, address width of requests and cache write port.
- CACHE_BLOCK_W, 128, block payload width in bits; power of two, ≥ 32.
- MAX_STREAK, 4, consecutive fill grants allowed while a push waits; ≥ 1.

Ports:
- aclk  in  1  clock; single clock domain.
- srst  in  1  synchronous active-high reset.
- fill_valid  in  1  fetcher block fill request.
- fill_ready  out  1  fill grant.
- fill_addr  in  AXI_ADDR_W  fill address.
- fill_data  in  CACHE_BLOCK_W  fill block data.
- fill_strb  in  CACHE_BLOCK_W/8  fill byte enables.
- push_valid  in  1  pusher update request.
- push_ready  out  1  push grant.
- push_addr  in  AXI_ADDR_W  update address.
- push_data  in  CACHE_BLOCK_W  update data, word-replicated across block.
- push_strb  in  CACHE_BLOCK_W/8  update byte enables, one word lane set.
- cache_wen  out  1  block write enable.
- cache_waddr  out  AXI_ADDR_W  block write address.
- cache_wdata  out  CACHE_BLOCK_W  block write data.
- cache_wstrb  out  CACHE_BLOCK_W/8  block write byte enables.
- pending  out  1  a request is waiting or a write is in flight.

## Operation
- Block compare: the low OFF_W = $clog2(CACHE_BLOCK_W/8) address bits are ignored. same_blk = (fill_addr >> OFF_W) == (push_addr >> OFF_W).
- Requesters hold valid and payload stable until ready. fill_ready and push_ready are combinational from the valids, same_blk and the streak counter; there is no combinational path from the cache_* outputs.
- Grant priority is evaluated every cycle; srst=1 forces both readies low:
  1. Merge: both valid and same_blk. Both readies go high. The write is addr=fill_addr, strb=fill_strb|push_strb, and for each byte b the data is push_strb[b] ? push_data byte : fill_data byte. Merge wins regardless of streak.
  2. Both valid, different blocks: push is granted if streak==MAX_STREAK, otherwise fill is granted.
  3. Only one valid: that requester is granted.
- streak counter, width $clog2(MAX_STREAK+1):
  - Cleared on srst, on any push grant (including merge), and whenever push_valid=0.
  - Incremented on a fill-only grant while push_valid=1; saturates at MAX_STREAK.
- Output stage is registered. The cycle after a grant: cache_wen=1 with the granted or merged address, data and strobe. With no grant: cache_wen=0 and cache_wstrb=0; cache_waddr and cache_wdata hold.
- pending = fill_valid | push_valid | cache_wen.
- One write per cycle maximum. Back-to-back grants produce back-to-back writes with no bubble.

## Timing
- Reset values (srst sampled high): cache_wen=0, cache_waddr=0, cache_wdata=0, cache_wstrb=0, streak=0. fill_ready and push_ready are 0 while srst=1.
- Grant-to-write latency: 1 cycle.
- Reset mid-operation: a grant in the srst cycle does not occur, and the in-flight output is cleared the next edge. Requesters must re-present after srst deasserts.
- A request made the first cycle after srst is granted that cycle.
- Starvation bound: with continuous fills to other blocks, a waiting push is granted within MAX_STREAK+1 cycles of asserting valid.
- Push with strb=0 is still granted and still produces cache_wen=1 with wstrb=0.
- Merge in which fill_strb and push_strb overlap: push bytes win.

## Test plan
- Reset: hold srst 3 cycles with both valids high → readies 0 throughout. Next cycle cache_wen=0, wstrb=0, waddr=0; fill is granted the first cycle after release.
- Single fill: fill_addr=0x40, data=pattern A, strb=all ones → fill_ready same cycle. Next cycle cache_wen=1, waddr=0x40, wdata=A, wstrb=0xFFFF. The following cycle cache_wen=0.
- Starvation (MAX_STREAK=2): continuous fills to 0x00, 0x10, 0x20…, push at 0x80 held valid → fill, fill, push, fill order. The push write appears on the 4th cycle; streak clears afterward.
- Merge: fill 0x40 all-ones strb with data A; push 0x44 strb=0x00F0 with data 0xDEADBEEF replicated → both ready in one cycle. Single write waddr=0x40, wstrb=0xFFFF, bytes 4–7 = 0xDEADBEEF, the rest from A.
- Different-block collision with streak<MAX: fill 0x40 and push 0x84 → fill granted, push waits, push written the next cycle. pending stays 1 until the cycle after the push write.
- Reset mid-burst: assert srst in a cycle where fill_valid=1 → no grant that cycle. cache_wen=0 the next cycle and streak=0.

Source files
------------

// File: rtl/friscv_cache_wr_arbiter_if.sv
// Bundle of the fill, push and cache write port signals around the data-cache
// block write arbiter. The slave modport is the arbiter's view and the master
// modport is the view of the environment that drives it.
interface friscv_cache_wr_arbiter_if #(
  parameter int AXI_ADDR_W    = 8,
  parameter int CACHE_BLOCK_W = 128
);

  logic                       fill_valid;
  logic                       fill_ready;
  logic [AXI_ADDR_W-1:0]      fill_addr;
  logic [CACHE_BLOCK_W-1:0]   fill_data;
  logic [CACHE_BLOCK_W/8-1:0] fill_strb;

  logic                       push_valid;
  logic                       push_ready;
  logic [AXI_ADDR_W-1:0]      push_addr;
  logic [CACHE_BLOCK_W-1:0]   push_data;
  logic [CACHE_BLOCK_W/8-1:0] push_strb;

  logic                       cache_wen;
  logic [AXI_ADDR_W-1:0]      cache_waddr;
  logic [CACHE_BLOCK_W-1:0]   cache_wdata;
  logic [CACHE_BLOCK_W/8-1:0] cache_wstrb;

  logic                       pending;

  modport slave (
    input  fill_valid, fill_addr, fill_data, fill_strb,
    input  push_valid, push_addr, push_data, push_strb,
    output fill_ready, push_ready,
    output cache_wen, cache_waddr, cache_wdata, cache_wstrb,
    output pending
  );

  modport master (
    output fill_valid, fill_addr, fill_data, fill_strb,
    output push_valid, push_addr, push_data, push_strb,
    input  fill_ready, push_ready,
    input  cache_wen, cache_waddr, cache_wdata, cache_wstrb,
    input  pending
  );

endinterface

// File: rtl/friscv_cache_wr_arbiter.sv
// Arbiter for the single data-cache block write port shared by the fetcher
// (line fills, priority) and the pusher (write-through updates). A streak
// counter bounds how long a waiting push can be starved by fills, and a fill
// and a push to the same block in one cycle are merged into a single write.
module friscv_cache_wr_arbiter #(
  parameter int AXI_ADDR_W    = 8,
  parameter int CACHE_BLOCK_W = 128,
  parameter int MAX_STREAK    = 4
) (
  input logic                    aclk,
  input logic                    srst,
  friscv_cache_wr_arbiter_if.slave bus
);

  localparam int NB     = CACHE_BLOCK_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int SW     = $clog2(MAX_STREAK + 1);

  logic                  same_blk;
  logic                  merge;
  logic                  streak_max;
  logic                  fill_gnt;
  logic                  push_gnt;

  logic [SW-1:0]         streak_d,  streak_q;
  logic                  wen_d,     wen_q;
  logic [AXI_ADDR_W-1:0] waddr_d,   waddr_q;
  logic [CACHE_BLOCK_W-1:0] wdata_d, wdata_q;
  logic [NB-1:0]         wstrb_d,   wstrb_q;
  logic [CACHE_BLOCK_W-1:0] merge_data;

  assign same_blk   = (bus.fill_addr >> OFF_W) == (bus.push_addr >> OFF_W);
  assign merge      = bus.fill_valid && bus.push_valid && same_blk;
  assign streak_max = (streak_q == SW'(MAX_STREAK));

  // Grant decision: merge first, then fill priority unless the streak is spent
  always_comb begin
    fill_gnt = 1'b0;
    push_gnt = 1'b0;
    if (!srst) begin
      if (merge) begin
        fill_gnt = 1'b1;
        push_gnt = 1'b1;
      end else if (bus.fill_valid && bus.push_valid) begin
        if (streak_max) push_gnt = 1'b1;
        else            fill_gnt = 1'b1;
      end else begin
        fill_gnt = bus.fill_valid;
        push_gnt = bus.push_valid;
      end
    end
  end

  assign bus.fill_ready = fill_gnt;
  assign bus.push_ready = push_gnt;

  // Streak tracks fill grants taken while a push is waiting
  always_comb begin
    streak_d = streak_q;
    if (push_gnt || !bus.push_valid) begin
      streak_d = '0;
    end else if (fill_gnt && !streak_max) begin
      streak_d = streak_q + SW'(1);
    end
  end

  // Byte-wise merge where push bytes override fill bytes
  always_comb begin
    merge_data = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      merge_data[b*8 +: 8] = bus.push_strb[b] ? bus.push_data[b*8 +: 8]
                                              : bus.fill_data[b*8 +: 8];
    end
  end

  // Next write port contents; address and data hold when nothing is granted
  always_comb begin
    wen_d   = 1'b0;
    wstrb_d = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (fill_gnt && push_gnt) begin
      wen_d   = 1'b1;
      waddr_d = bus.fill_addr;
      wdata_d = merge_data;
      wstrb_d = bus.fill_strb | bus.push_strb;
    end else if (fill_gnt) begin
      wen_d   = 1'b1;
      waddr_d = bus.fill_addr;
      wdata_d = bus.fill_data;
      wstrb_d = bus.fill_strb;
    end else if (push_gnt) begin
      wen_d   = 1'b1;
      waddr_d = bus.push_addr;
      wdata_d = bus.push_data;
      wstrb_d = bus.push_strb;
    end
  end

  // Registered write port and streak counter
  always_ff @(posedge aclk) begin
    if (srst) begin
      streak_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      streak_q <= streak_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  assign bus.cache_wen   = wen_q;
  assign bus.cache_waddr = waddr_q;
  assign bus.cache_wdata = wdata_q;
  assign bus.cache_wstrb = wstrb_q;
  assign bus.pending     = bus.fill_valid | bus.push_valid | wen_q;

endmodule
